// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows: row-major bytes in, column-major inverse-shifted bytes out.
// Two 16-byte ping-pong banks form a two-block FIFO so both sides can run at one byte per cycle.
module inv_shift_rows_stream (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       sink_valid,
  output logic       sink_ready,
  input  logic [7:0] sink_data,
  input  logic       sink_last,
  output logic       source_valid,
  input  logic       source_ready,
  output logic [7:0] source_data,
  output logic       source_last,
  output logic       err_framing
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic [DATA_W-1:0] r_bank [2][DEPTH];
  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [3:0]        r_wr_cnt;
  logic [3:0]        r_rd_cnt;
  logic              r_err;

  logic              w_wr_hs;
  logic              w_rd_hs;
  logic              w_wr_done;
  logic              w_wr_bad;
  logic              w_rd_done;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;
  logic [DATA_W-1:0] w_rd_byte;

  // Output position 4c+r reads stored position 4r + ((c - r) mod 4).
  function automatic logic [3:0] inv_idx(input logic [3:0] cnt);
    logic [1:0] col;
    logic [1:0] row;
    logic [1:0] src_col;
    col     = cnt[3:2];
    row     = cnt[1:0];
    src_col = col - row;
    return {row, src_col};
  endfunction

  assign sink_ready   = ~r_full[r_wr_sel];
  assign source_valid = r_full[r_rd_sel];
  assign w_wr_hs      = sink_valid & sink_ready;
  assign w_rd_hs      = source_valid & source_ready;

  assign w_wr_done    = w_wr_hs & sink_last & (r_wr_cnt == 4'hF);
  assign w_wr_bad     = w_wr_hs & (sink_last ^ (r_wr_cnt == 4'hF));
  assign w_rd_done    = w_rd_hs & (r_rd_cnt == 4'hF);

  assign w_rd_byte    = r_bank[r_rd_sel][inv_idx(r_rd_cnt)];
  assign source_data  = source_valid ? w_rd_byte : '0;
  assign source_last  = source_valid & (r_rd_cnt == 4'hF);
  assign err_framing  = r_err;

  // Set and clear never target the same bank: a full bank blocks its own writes.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_wr_done) w_set[r_wr_sel] = 1'b1;
    if (w_rd_done) w_clr[r_rd_sel] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_hs) r_bank[r_wr_sel][r_wr_cnt] <= sink_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err  <= w_wr_bad;
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_wr_done) begin
        r_wr_sel <= ~r_wr_sel;
        r_wr_cnt <= '0;
      end else if (w_wr_bad) begin
        r_wr_cnt <= '0;
      end else if (w_wr_hs) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
      end
      if (w_rd_done) begin
        r_rd_sel <= ~r_rd_sel;
        r_rd_cnt <= '0;
      end else if (w_rd_hs) begin
        r_rd_cnt <= r_rd_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Bench for inv_shift_rows_stream: randomized blocks checked every cycle against a
// block-level reference model (occupancy count plus expected-byte queue).
module tb_inv_shift_rows_stream;

  typedef logic [7:0] blk_t [16];

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       sink_valid = 1'b0;
  logic       sink_ready;
  logic [7:0] sink_data = 8'h00;
  logic       sink_last = 1'b0;
  logic       source_valid;
  logic       source_ready = 1'b0;
  logic [7:0] source_data;
  logic       source_last;
  logic       err_framing;

  inv_shift_rows_stream dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_data    (sink_data),
    .sink_last    (sink_last),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_data  (source_data),
    .source_last  (source_last),
    .err_framing  (err_framing)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference transforms straight from the AES definitions.
  function automatic blk_t inv_sr(input blk_t f);
    blk_t x;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        x[4*c + r] = f[4*r + ((c - r + 4) % 4)];
    return x;
  endfunction

  function automatic blk_t fwd_sr(input blk_t x);
    blk_t f;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        f[4*r + c] = x[4*((c + r) % 4) + r];
    return f;
  endfunction

  // Model state: complete blocks held, expected output bytes, partial input block.
  logic [7:0] out_q[$];
  logic [7:0] cur_q[$];
  logic [7:0] cap_q[$];
  int         in_cyc[$];
  int         out_cyc[$];
  int         held = 0;
  int         out_pos = 0;
  int         cyc = 0;
  int         n_in = 0;
  int         n_err_obs = 0;
  bit         exp_err = 0;
  bit         model_ok = 0;
  bit         m_in_hs;
  bit         m_out_hs;
  blk_t       m_f;
  blk_t       m_x;
  int         rdy_mode = 0;

  // Outputs are checked mid-cycle; the handshakes of the coming edge are then applied.
  always @(negedge sys_clk) begin
    cyc++;
    if (model_ok) begin
      chk_val("sink_ready", 32'(sink_ready), 32'(held < 2));
      chk_val("src_valid", 32'(source_valid), 32'(held > 0));
      if (held > 0) begin
        chk_val("src_data", 32'(source_data), 32'(out_q[0]));
        chk_val("src_last", 32'(source_last), 32'(out_pos == 15));
      end else begin
        chk_val("src_data_idle", 32'(source_data), 32'h0);
        chk_val("src_last_idle", 32'(source_last), 32'h0);
      end
      chk_val("err_framing", 32'(err_framing), 32'(exp_err));
      if (err_framing === 1'b1) n_err_obs++;
    end
    if (sys_rst) begin
      out_q.delete();
      cur_q.delete();
      held     = 0;
      out_pos  = 0;
      exp_err  = 0;
      model_ok = 1;
    end else if (model_ok) begin
      m_in_hs  = sink_valid && (held < 2);
      m_out_hs = (held > 0) && source_ready;
      exp_err  = 0;
      if (m_out_hs) begin
        cap_q.push_back(source_data);
        out_cyc.push_back(cyc);
        void'(out_q.pop_front());
        out_pos++;
        if (out_pos == 16) begin
          out_pos = 0;
          held--;
        end
      end
      if (m_in_hs) begin
        n_in++;
        in_cyc.push_back(cyc);
        cur_q.push_back(sink_data);
        if (cur_q.size() == 16 && sink_last) begin
          for (int i = 0; i < 16; i++) m_f[i] = cur_q[i];
          m_x = inv_sr(m_f);
          for (int i = 0; i < 16; i++) out_q.push_back(m_x[i]);
          held++;
          cur_q.delete();
        end else if (cur_q.size() == 16 || sink_last) begin
          exp_err = 1;
          cur_q.delete();
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      case (rdy_mode)
        0:       source_ready = 1'b0;
        1:       source_ready = 1'b1;
        default: source_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    sink_valid = 1'b1;
    sink_data  = d;
    sink_last  = l;
    @(negedge sys_clk);
    while (!sink_ready && t < 1000) begin
      t++;
      @(negedge sys_clk);
    end
    if (t >= 1000) chk_val("sink_timeout", 32'(sink_ready), 32'h1);
    @(posedge sys_clk);
    #1;
    sink_valid = 1'b0;
    sink_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (held > 0 && t < 3000) begin
      @(posedge sys_clk);
      t++;
    end
    if (t >= 3000) chk_val("drain_timeout", 32'(source_valid), 32'h0);
    idle(2);
  endtask

  task automatic chk_tbl(input string tag, input blk_t tbl);
    chk_val({tag, "_count"}, 32'(cap_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < cap_q.size(); i++)
      chk_val(tag, 32'(cap_q[i]), 32'(tbl[i]));
  endtask

  blk_t       tbl;
  blk_t       bx;
  blk_t       bf;
  logic [7:0] rt_q[$];
  int         base;
  int         e0;
  int         o_first;
  int         o_last;
  int         i_first;

  initial begin
    tbl = '{8'h00, 8'h07, 8'h0A, 8'h0D, 8'h01, 8'h04, 8'h0B, 8'h0E,
            8'h02, 8'h05, 8'h08, 8'h0F, 8'h03, 8'h06, 8'h09, 8'h0C};
    idle(2);
    sys_rst = 1'b0;
    rdy_mode = 1;
    idle(1);

    // Single block of 0x00..0x0F
    cap_q.delete();
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    wait_drain();
    chk_tbl("single", tbl);

    // Back-to-back: 8 random blocks, both sides always ready
    cap_q.delete(); in_cyc.delete(); out_cyc.delete();
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 16; i++) send_byte(8'($urandom), i == 15);
    wait_drain();
    chk_val("b2b_count", 32'(out_cyc.size()), 32'd128);
    o_first = (out_cyc.size() > 0) ? out_cyc[0] : 0;
    o_last  = (out_cyc.size() >= 128) ? out_cyc[127] : 0;
    i_first = (in_cyc.size() > 0) ? in_cyc[0] : 0;
    chk_val("b2b_span", 32'(o_last - o_first), 32'd127);
    chk_val("b2b_fill", 32'(o_first - i_first), 32'd16);

    // Backpressure: three blocks against a stalled sink
    cap_q.delete();
    rdy_mode = 0;
    idle(1);
    base = n_in;
    fork
      begin
        for (int b = 0; b < 3; b++)
          for (int i = 0; i < 16; i++) send_byte(8'($urandom), i == 15);
      end
      begin
        idle(80);
        chk_val("bp_accepted", 32'(n_in - base), 32'd32);
        chk_val("bp_sink_ready", 32'(sink_ready), 32'h0);
        rdy_mode = 1;
      end
    join
    wait_drain();
    chk_val("bp_out_count", 32'(cap_q.size()), 32'd48);

    // Framing: early last, then a good block, then a block without last
    cap_q.delete();
    e0 = n_err_obs;
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), i == 5);
    idle(4);
    chk_val("frm_early_err", 32'(n_err_obs - e0), 32'd1);
    chk_val("frm_early_out", 32'(cap_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    wait_drain();
    chk_tbl("frm_good", tbl);
    cap_q.delete();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    idle(4);
    chk_val("frm_nolast_err", 32'(n_err_obs - e0), 32'd2);
    chk_val("frm_nolast_out", 32'(cap_q.size()), 32'd0);

    // Round trip through a forward ShiftRows model, random gaps and backpressure
    cap_q.delete();
    rt_q.delete();
    rdy_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 16; i++) bx[i] = (n == 0) ? 8'(i) : 8'($urandom);
      bf = fwd_sr(bx);
      for (int i = 0; i < 16; i++) rt_q.push_back(bx[i]);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(3) == 0) idle(1);
        send_byte(bf[i], i == 15);
      end
    end
    wait_drain();
    chk_val("rt_count", 32'(cap_q.size()), 32'(rt_q.size()));
    for (int i = 0; i < cap_q.size() && i < rt_q.size(); i++)
      chk_val("rt_byte", 32'(cap_q[i]), 32'(rt_q[i]));

    // Reset mid-stream with one block pending and a partial block
    rdy_mode = 0;
    idle(1);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), i == 15);
    sys_rst = 1'b1;
    idle(1);
    sys_rst = 1'b0;
    chk_val("rst_sink_ready", 32'(sink_ready), 32'h1);
    chk_val("rst_src_valid", 32'(source_valid), 32'h0);
    chk_val("rst_src_data", 32'(source_data), 32'h0);
    chk_val("rst_src_last", 32'(source_last), 32'h0);
    chk_val("rst_err", 32'(err_framing), 32'h0);
    rdy_mode = 1;
    cap_q.delete();
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    wait_drain();
    chk_tbl("post_rst", tbl);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
